// File: rtl/dcache_set_assoc_if.sv
// CPU-side request/response bus and memory-side refill/write-back bus of the
// data cache, bundled so the cache and its environment share one definition.
//   slave  : cache view (accepts CPU requests, issues memory requests)
//   master : environment view (issues CPU requests, answers memory requests)
interface dcache_set_assoc_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_miss;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_write;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [31:0]       mem_wdata;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    input  mem_req_ready, mem_rvalid, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_miss,
    output mem_req_valid, mem_req_write, mem_req_addr, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    output mem_req_ready, mem_rvalid, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_miss,
    input  mem_req_valid, mem_req_write, mem_req_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_set_assoc.sv
// Set-associative write-back / write-allocate data cache with a miss FSM that
// writes back a dirty victim word by word, refills the line, then replays the
// access. Saturating hit/miss counters for performance measurement.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : CPU request/response and memory request/refill signals
//   hit_cnt      : saturating count of first-time hits
//   miss_cnt     : saturating count of misses
module dcache_set_assoc #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned WAYS   = 2,
  parameter int unsigned SETS   = 8,
  parameter int unsigned WORDS  = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  dcache_set_assoc_if.slave    bus,
  output logic [31:0]          hit_cnt,
  output logic [31:0]          miss_cnt
);

  localparam int unsigned WORD_B  = $clog2(WORDS);
  localparam int unsigned IDX_B   = $clog2(SETS);
  localparam int unsigned LINE_SH = WORD_B + 2;
  localparam int unsigned TAG_W   = ADDR_W - LINE_SH - IDX_B;
  localparam int unsigned WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned WSEL_W  = (WORDS > 1) ? WORD_B : 1;
  localparam int unsigned WA_W    = ADDR_W - 2;

  typedef enum logic [2:0] {IDLE, LOOKUP, WB, RF_REQ, RF_DATA} state_t;

  state_t state_q, state_d;

  // Line storage; valid/dirty/rr are reset, tags and data are not.
  logic              valid_q [SETS][WAYS];
  logic              dirty_q [SETS][WAYS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [31:0]       data_q  [SETS][WAYS][WORDS];
  logic [WAY_W-1:0]  rr_q    [SETS];

  // Registered request (word address only; byte offset is ignored).
  logic              write_q;
  logic [WA_W-1:0]   wa_q;
  logic [31:0]       wdata_q;
  logic              replay_q;
  logic [WAY_W-1:0]  victim_q;
  logic [WSEL_W-1:0] beat_q;

  logic [IDX_B-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [WSEL_W-1:0] word;
  logic              hit, inv_found, beat_last;
  logic [WAY_W-1:0]  hit_way, victim, rr_next;

  assign idx       = IDX_B'(wa_q >> WORD_B);
  assign tag       = TAG_W'(wa_q >> (WORD_B + IDX_B));
  assign word      = (WORDS > 1) ? WSEL_W'(wa_q) : '0;
  assign beat_last = (beat_q == WSEL_W'(WORDS - 1));
  assign rr_next   = (rr_q[idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[idx] + WAY_W'(1);

  // Tag match across the set, and victim choice: lowest invalid way else RR.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    victim    = rr_q[idx];
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[idx][w]) begin
        inv_found = 1'b1;
        victim    = WAY_W'(w);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req_valid) state_d = LOOKUP;
      LOOKUP: begin
        if (hit)                                             state_d = IDLE;
        else if (valid_q[idx][victim] && dirty_q[idx][victim]) state_d = WB;
        else                                                 state_d = RF_REQ;
      end
      WB:      if (bus.mem_req_ready && beat_last) state_d = RF_REQ;
      RF_REQ:  if (bus.mem_req_ready)              state_d = RF_DATA;
      RF_DATA: if (bus.mem_rvalid && beat_last)    state_d = LOOKUP;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode from registered state only; idle values are all zero.
  assign bus.req_ready     = (state_q == IDLE);
  assign bus.resp_valid    = (state_q == LOOKUP) && hit;
  assign bus.resp_rdata    = !bus.resp_valid ? 32'd0 :
                             (write_q ? wdata_q : data_q[idx][hit_way][word]);
  assign bus.resp_miss     = bus.resp_valid && replay_q;
  assign bus.mem_req_valid = (state_q == WB) || (state_q == RF_REQ);
  assign bus.mem_req_write = (state_q == WB);
  assign bus.mem_req_addr  =
    (state_q == WB)     ? ((ADDR_W'({tag_q[idx][victim_q], idx}) << LINE_SH) |
                           (ADDR_W'(beat_q) << 2)) :
    (state_q == RF_REQ) ? {(wa_q >> WORD_B) << WORD_B, 2'b00} : '0;
  assign bus.mem_wdata     = (state_q == WB) ? data_q[idx][victim_q][beat_q] : 32'd0;

  // Request capture, line status bits, RR pointers, beat counter, counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      write_q  <= 1'b0;
      wa_q     <= '0;
      wdata_q  <= '0;
      replay_q <= 1'b0;
      victim_q <= '0;
      beat_q   <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
      for (int s = 0; s < SETS; s++) begin
        rr_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
        end
      end
    end else begin
      case (state_q)
        IDLE: if (bus.req_valid) begin
          write_q  <= bus.req_write;
          wa_q     <= bus.req_addr[ADDR_W-1:2];
          wdata_q  <= bus.req_wdata;
          replay_q <= 1'b0;
        end
        LOOKUP: begin
          if (hit) begin
            if (write_q) dirty_q[idx][hit_way] <= 1'b1;
            if (!replay_q && hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
          end else begin
            if (miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
            victim_q <= victim;
            beat_q   <= '0;
            if (!inv_found) rr_q[idx] <= rr_next;
          end
        end
        WB: if (bus.mem_req_ready) beat_q <= beat_last ? '0 : beat_q + WSEL_W'(1);
        RF_REQ: if (bus.mem_req_ready) begin
          // Invalidate before any refill beat lands so a partial line never hits.
          valid_q[idx][victim_q] <= 1'b0;
          dirty_q[idx][victim_q] <= 1'b0;
          beat_q                 <= '0;
        end
        RF_DATA: if (bus.mem_rvalid) begin
          beat_q <= beat_last ? '0 : beat_q + WSEL_W'(1);
          if (beat_last) begin
            valid_q[idx][victim_q] <= 1'b1;
            dirty_q[idx][victim_q] <= 1'b0;
            replay_q               <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag and data arrays: store hits and refill beats.
  always_ff @(posedge clk) begin
    if (state_q == LOOKUP && hit && write_q)
      data_q[idx][hit_way][word] <= wdata_q;
    if (state_q == RF_DATA && bus.mem_rvalid) begin
      data_q[idx][victim_q][beat_q] <= bus.mem_rdata;
      if (beat_last) tag_q[idx][victim_q] <= tag;
    end
  end

endmodule

// File: tb/tb_dcache_set_assoc.sv
// Randomised + directed bench for dcache_set_assoc (WAYS=2, SETS=4, WORDS=2)
// with a line-level reference model, a word-addressed backing memory and a
// scoreboard-driven response monitor.
module tb_dcache_set_assoc;
  localparam int unsigned AW = 32, WAYS = 2, SETS = 4, WORDS = 2;

  logic clk = 1'b0;
  logic reset_n;
  logic [31:0] hit_cnt, miss_cnt;
  always #5 clk = ~clk;

  dcache_set_assoc_if #(.ADDR_W(AW)) bus ();

  dcache_set_assoc #(.ADDR_W(AW), .WAYS(WAYS), .SETS(SETS), .WORDS(WORDS)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  int checks = 0, errors = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {logic [31:0] rdata; logic miss; int lat;} resp_t;
  typedef struct {logic [31:0] addr; logic [31:0] data;} wr_t;
  resp_t       sb[$];
  int unsigned acc_q[$];
  wr_t         exp_wb[$];
  logic [31:0] exp_rd[$];

  // Reference model: line bookkeeping plus architectural memory contents.
  bit          m_valid[SETS][WAYS];
  bit          m_dirty[SETS][WAYS];
  int unsigned m_tag[SETS][WAYS];
  int unsigned m_rr[SETS];
  logic [31:0] gold[logic [31:0]];
  logic [31:0] bmem[logic [31:0]];
  int exp_hits, exp_miss;
  int mem_mode = 0;       // 0 always ready, 1 random, 2 five-cycle stall per request
  int stall_seen = 0;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction
  function automatic logic [31:0] gval(input logic [31:0] a);
    return gold.exists(a) ? gold[a] : init_val(a);
  endfunction
  function automatic logic [31:0] bval(input logic [31:0] a);
    return bmem.exists(a) ? bmem[a] : init_val(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic reset_model();
    for (int s = 0; s < SETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 0; m_dirty[s][w] = 0; m_tag[s][w] = 0;
      end
    end
    gold.delete(); bmem.delete();
    gold[32'h1000] = 32'h9999_9999; bmem[32'h1000] = 32'h9999_9999;
    gold[32'h1004] = 32'hAAAA_AAAA; bmem[32'h1004] = 32'hAAAA_AAAA;
    exp_hits = 0; exp_miss = 0;
    sb.delete(); acc_q.delete(); exp_wb.delete(); exp_rd.delete();
  endtask

  task automatic model_access(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                              output resp_t r);
    int unsigned s = (a >> 3) % SETS;
    int unsigned t = a >> 5;
    int way = -1;
    bit wb = 0;
    logic [31:0] la;
    for (int w = 0; w < WAYS; w++) if (m_valid[s][w] && m_tag[s][w] == t) way = w;
    r.miss = (way < 0);
    if (way < 0) begin
      exp_miss++;
      for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[s][w]) way = w;
      if (way < 0) begin
        way = int'(m_rr[s]);
        m_rr[s] = (m_rr[s] + 1) % WAYS;
      end
      if (m_valid[s][way] && m_dirty[s][way]) begin
        wb = 1;
        for (int ww = 0; ww < WORDS; ww++) begin
          la = (m_tag[s][way] << 5) | (s << 3) | (ww << 2);
          exp_wb.push_back('{addr: la, data: gval(la)});
        end
      end
      exp_rd.push_back(a & ~32'h7);
      m_valid[s][way] = 1; m_tag[s][way] = t; m_dirty[s][way] = 0;
    end else begin
      exp_hits++;
    end
    if (wr) begin
      gold[a & ~32'h3] = wd;
      m_dirty[s][way] = 1;
      r.rdata = wd;
    end else begin
      r.rdata = gval(a & ~32'h3);
    end
    r.lat = (mem_mode != 0) ? -1 : (!r.miss ? 0 : 2 + WORDS + (wb ? WORDS : 0));
  endtask

  // Issue one access: predict, push expectation, hold req_valid until accepted.
  task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] wd);
    resp_t r;
    int n = 0;
    model_access(wr, a, wd, r);
    sb.push_back(r);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = a; bus.req_wdata = wd;
    while (!bus.req_ready && n < 500) begin @(negedge clk); n++; end
    if (!bus.req_ready) check("accept_timeout", 32'd0, 32'd1);
    acc_q.push_back(cyc + 1);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || !bus.req_ready) && n < 1000) begin @(negedge clk); n++; end
    if (n >= 1000) check("idle_timeout", 32'd0, 32'd1);
    check("mem_traffic_pending", 32'(exp_wb.size() + exp_rd.size()), 32'd0);
  endtask

  task automatic wait_rvalid();
    int n = 0;
    do begin @(negedge clk); #1; n++; end while (!bus.mem_rvalid && n < 200);
    if (!bus.mem_rvalid) check("rvalid_timeout", 32'd0, 32'd1);
  endtask

  // Response monitor: pops the scoreboard whenever the cache responds.
  always @(negedge clk) begin
    resp_t r;
    int unsigned acc;
    if (reset_n === 1'b1 && bus.resp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        r = sb.pop_front();
        acc = (acc_q.size() != 0) ? acc_q.pop_front() : 0;
        check("resp_rdata", bus.resp_rdata, r.rdata);
        check("resp_miss", 32'(bus.resp_miss), 32'(r.miss));
        if (r.lat >= 0) check("resp_latency", cyc - acc, 32'(r.lat));
      end
    end
  end

  // Backing memory: ready/valid handshakes, refill beats, stall checks.
  logic [31:0] beats[$];
  bit          prev_stall = 0;
  logic [31:0] p_addr, p_wdata;
  logic        p_write;
  int          stall_left = 5;
  always @(negedge clk) begin
    wr_t e;
    logic [31:0] ea;
    if (reset_n !== 1'b1) begin
      beats.delete();
      bus.mem_rvalid = 1'b0; bus.mem_rdata = '0; bus.mem_req_ready = 1'b0;
      prev_stall = 0; stall_left = 5;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(bus.mem_req_valid), 32'd1);
        check("stall_addr", bus.mem_req_addr, p_addr);
        check("stall_wdata", bus.mem_wdata, p_wdata);
        check("stall_write", 32'(bus.mem_req_write), 32'(p_write));
      end
      if (beats.size() != 0 && (mem_mode != 1 || $urandom_range(0, 3) != 0)) begin
        bus.mem_rvalid = 1'b1; bus.mem_rdata = beats.pop_front();
      end else begin
        bus.mem_rvalid = 1'b0; bus.mem_rdata = $urandom;
      end
      if (mem_mode != 2) stall_left = 5;
      if (mem_mode == 2 && bus.mem_req_valid && stall_left > 0) begin
        bus.mem_req_ready = 1'b0; stall_left--; stall_seen++;
      end else if (mem_mode == 1) begin
        bus.mem_req_ready = ($urandom_range(0, 9) < 7);
      end else begin
        bus.mem_req_ready = 1'b1;
      end
      if (bus.mem_req_valid && bus.mem_req_ready) begin
        if (bus.mem_req_write) begin
          bmem[bus.mem_req_addr] = bus.mem_wdata;
          if (exp_wb.size() == 0) check("unexpected_mem_write", bus.mem_req_addr, 32'hFFFF_FFFF);
          else begin
            e = exp_wb.pop_front();
            check("wb_addr", bus.mem_req_addr, e.addr);
            check("wb_data", bus.mem_wdata, e.data);
          end
        end else begin
          if (exp_rd.size() == 0) check("unexpected_mem_read", bus.mem_req_addr, 32'hFFFF_FFFF);
          else begin
            ea = exp_rd.pop_front();
            check("refill_addr", bus.mem_req_addr, ea);
          end
          for (int w = 0; w < WORDS; w++) beats.push_back(bval(bus.mem_req_addr + 32'(4 * w)));
        end
        stall_left = 5;
      end
      prev_stall = bus.mem_req_valid && !bus.mem_req_ready;
      p_addr = bus.mem_req_addr; p_wdata = bus.mem_wdata; p_write = bus.mem_req_write;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    int s0;
    logic [31:0] a;
    reset_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    reset_model();
    repeat (3) @(negedge clk);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_hit_cnt", hit_cnt, 32'd0);
    check("rst_miss_cnt", miss_cnt, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);

    // Cold miss then hit on the other word of the line.
    access(0, 32'h0000_1004, '0);
    wait_idle();
    check("miss_cnt_cold", miss_cnt, 32'd1);
    access(0, 32'h0000_1000, '0);
    wait_idle();
    check("hit_cnt_first", hit_cnt, 32'd1);

    // Store hit and read-back.
    access(1, 32'h0000_1000, 32'hACAC_ACAC);
    access(0, 32'h0000_1000, '0);
    wait_idle();

    // Fill way1, then evict dirty way0.
    access(0, 32'h0000_2000, '0);
    access(0, 32'h0000_3000, '0);
    wait_idle();
    check("miss_cnt_evict", miss_cnt, 32'd3);
    check("hit_cnt_evict", hit_cnt, 32'(exp_hits));

    // Memory backpressure during write-back and refill request.
    access(1, 32'h0000_3000, 32'h1234_5678);
    access(1, 32'h0000_2004, 32'h0BAD_F00D);
    wait_idle();
    s0 = stall_seen;
    mem_mode = 2;
    access(0, 32'h0000_5000, '0);
    wait_idle();
    mem_mode = 0;
    check("stall_cycles", 32'(stall_seen - s0), 32'd15);

    // Request pulse while refilling must be ignored.
    access(0, 32'h0000_6000, '0);
    wait_rvalid();
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h0000_4000;
    @(negedge clk);
    bus.req_valid = 1'b0;
    wait_idle();
    repeat (10) @(negedge clk);
    check("busy_miss_cnt", miss_cnt, 32'(exp_miss));
    check("busy_hit_cnt", hit_cnt, 32'(exp_hits));

    // Reset after the first refill beat.
    access(0, 32'h0000_7000, '0);
    wait_rvalid();
    @(posedge clk);
    #2 reset_n = 1'b0;
    sb.delete(); acc_q.delete(); exp_wb.delete(); exp_rd.delete();
    @(negedge clk);
    check("mid_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("mid_rst_mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
    check("mid_rst_hit_cnt", hit_cnt, 32'd0);
    check("mid_rst_miss_cnt", miss_cnt, 32'd0);
    reset_n = 1'b1;
    reset_model();
    @(negedge clk);
    check("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
    access(0, 32'h0000_1004, '0);
    wait_idle();
    check("miss_cnt_after_reset", miss_cnt, 32'd1);

    // Random traffic over a small conflicting address pool.
    mem_mode = 1;
    for (int i = 0; i < 300; i++) begin
      a = 32'h0001_0000 + (32'($urandom_range(0, 5)) << 5) +
          (32'($urandom_range(0, SETS - 1)) << 3) + (32'($urandom_range(0, WORDS - 1)) << 2);
      access($urandom_range(0, 9) < 4, a, $urandom);
    end
    wait_idle();
    mem_mode = 0;
    check("final_hit_cnt", hit_cnt, 32'(exp_hits));
    check("final_miss_cnt", miss_cnt, 32'(exp_miss));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dcache_set_assoc.md
Name: dcache_set_assoc

Overview:
Parametrised set-associative, write-back, write-allocate data cache that sits between the LEGv8 datapath's load/store stage and backing memory. It generalises the earlier fixed hit/miss lookup store in two ways:
- configurable ways, sets and line length;
- a miss-handling FSM that performs dirty-victim write-back and line refill over a ready/valid memory port, then replays the access.
Saturating hit and miss counters are provided for performance measurement.

Parameters:
ADDR_W, 32, address width in bits; data words are fixed at 32 bits, word aligned, addr[1:0] ignored
WAYS, 2, associativity; power of 2, 1..8
SETS, 8, number of sets; power of 2, >=2
WORDS, 2, 32-bit words per line; power of 2, >=1

Ports:
clk  in  1  clock, all state changes on rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  CPU access request
req_ready  out  1  cache can accept a request
req_write  in  1  1 = store, 0 = load
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data
resp_valid  out  1  one-cycle pulse: access complete
resp_rdata  out  32  load data, valid with resp_valid; for stores, the value written
resp_miss  out  1  with resp_valid: access needed a refill
mem_req_valid  out  1  memory request
mem_req_ready  in  1  memory accepts request
mem_req_write  out  1  1 = write one word, 0 = read whole line
mem_req_addr  out  ADDR_W  word address (write) or line-aligned address (read)
mem_wdata  out  32  write-back word
mem_rvalid  in  1  refill beat valid
mem_rdata  in  32  refill beat data
hit_cnt  out  32  saturating hit count
miss_cnt  out  32  saturating miss count

Behaviour:
- Address split: offset [1:0] ignored; word = next log2(WORDS) bits; index = next log2(SETS) bits; tag = remaining upper bits.
- Per line storage: valid, dirty, tag, WORDS data words. Per set: round-robin victim pointer of log2(WAYS) bits.
- Reset (async, reset_n low):
  - all valid, dirty and RR pointers cleared; state IDLE;
  - req_ready=1 once released; all other outputs 0; counters 0;
  - data RAM contents unspecified.
- FSM states: IDLE, LOOKUP, WB, RF_REQ, RF_DATA.
- IDLE:
  - req_ready=1.
  - On req_valid: register write/addr/wdata and go to LOOKUP.
  - req_ready=0 in every other state; req_valid is ignored there and the requester must hold it.
- LOOKUP: compare tag against all ways of the indexed set.
  - Hit:
    - resp_valid=1 this cycle, i.e. 1 cycle after accept.
    - Load: resp_rdata = selected word.
    - Store: write word, set dirty, resp_rdata = wdata.
    - resp_miss = 1 if this LOOKUP is a replay, else 0. hit_cnt += 1 only on a non-replay. Go to IDLE.
  - Miss:
    - miss_cnt += 1.
    - Victim = lowest-index invalid way; if none, the RR pointer way, and the pointer then advances modulo WAYS.
    - Victim valid and dirty -> WB; otherwise -> RF_REQ.
- WB:
  - Issue WORDS write requests, word 0 first; mem_req_addr = {victim tag, index, word, 2'b00}.
  - Each request holds valid/addr/wdata stable until mem_req_ready.
  - After the last request is accepted -> RF_REQ.
- RF_REQ: one read request with the line-aligned address of the registered request, held until mem_req_ready, then -> RF_DATA.
- RF_DATA:
  - Accept exactly WORDS mem_rvalid beats in word order into the victim line.
  - After the last beat: valid=1, tag updated, dirty=0; -> LOOKUP (replay, which now hits).
  - mem_rvalid outside RF_DATA is ignored.
- Miss latency, with memory always ready and the first beat returning the cycle after the read is accepted: 2 + WORDS cycles, plus WORDS extra cycles if a write-back occurs.
- Counters saturate at 32'hFFFF_FFFF.
- Reset during WB, RF_REQ or RF_DATA:
  - the transaction is abandoned and mem_req_valid drops immediately;
  - the partially filled line stays invalid;
  - the memory model must be reset alongside the cache.
- WAYS=1 degenerates to direct-mapped; the RR pointer is unused.

Test Plan:
All scenarios use WAYS=2, SETS=4, WORDS=2; index = addr[4:3], word = addr[2].
1. Cold read miss: read 0x0000_1004 after reset.
   - Required: mem read to 0x0000_1000; beats 0x99999999, 0xAAAAAAAA.
   - Response: resp_rdata=0xAAAAAAAA, resp_miss=1, miss_cnt=1.
   - Then read 0x0000_1000: resp_valid 1 cycle after accept, data 0x99999999, resp_miss=0, hit_cnt=1, no memory traffic.
2. Store hit: write 0x0000_1000 = 0xACACACAC.
   - Required: hit, no memory traffic.
   - Read 0x0000_1000 -> 0xACACACAC.
3. Dirty eviction, continuing from 2:
   - Read 0x0000_2000 -> miss, fills way1, no write-back.
   - Read 0x0000_3000 -> victim way0 (RR=0).
   - Required: writes to 0x1000 with 0xACACACAC, then 0x1004 with 0xAAAAAAAA, then a read of 0x3000.
   - miss_cnt=3.
4. Backpressure: hold mem_req_ready=0 for 5 cycles during WB and again during RF_REQ.
   - Required: mem_req_valid, mem_req_addr and mem_wdata remain stable; request accepted only on the ready cycle.
5. Reset mid-refill: drive reset_n low after the first RF_DATA beat.
   - Required: outputs return to 0 and req_ready=1 after release.
   - Next read 0x0000_1004 misses, miss_cnt=1.
6. Request while busy: pulse req_valid with 0x0000_4000 during RF_DATA, then drop it.
   - Required: request ignored; no second response; state unaffected.
